// File: rtl/fg_wave_monitor.sv
// Waveform monitor for the function generator output: measures samples per period between
// upward mid-scale crossings (with hysteresis) and the min/max over that span.
module fg_wave_monitor #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MID    = 128,
    parameter int unsigned HYST   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CNT_W-1:0]  period_o,
    output logic [DATA_W-1:0] min_o,
    output logic [DATA_W-1:0] max_o,
    output logic              timeout_o
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSeek    = 2'd1;
    localparam logic [1:0] StMeasure = 2'd2;
    localparam logic [1:0] StReport  = 2'd3;

    localparam logic [DATA_W-1:0] LoTh   = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0] HiTh   = DATA_W'(MID + HYST);
    localparam logic [CNT_W-1:0]  CntMax = {CNT_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic              arm_q, arm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mn_q, mn_d;
    logic [DATA_W-1:0] mx_q, mx_d;
    logic              res_valid_q, res_valid_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              timeout_q, timeout_d;

    logic is_lo;
    logic is_hi;
    logic crossing;

    assign is_lo    = sample_valid_i && (sample_i <= LoTh);
    assign is_hi    = sample_valid_i && (sample_i >= HiTh);
    assign crossing = is_hi && arm_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mn_d        = mn_q;
        mx_d        = mx_q;
        res_valid_d = res_valid_q;
        period_d    = period_q;
        min_d       = min_q;
        max_d       = max_q;
        timeout_d   = timeout_q;

        // Flag tracking is common to every state; IDLE overrides it below.
        if (crossing) begin
            arm_d = 1'b0;
        end else if (is_lo) begin
            arm_d = 1'b1;
        end else begin
            arm_d = arm_q;
        end

        unique case (state_q)
            StIdle: begin
                arm_d = 1'b0;
                if (en_i) begin
                    state_d = StSeek;
                end
            end

            StSeek: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else if (crossing) begin
                    cnt_d   = CNT_W'(1);
                    mn_d    = sample_i;
                    mx_d    = sample_i;
                    state_d = StMeasure;
                end
            end

            StMeasure: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else if (crossing) begin
                    // Terminating crossing sample is not part of the measured span.
                    period_d    = cnt_q;
                    min_d       = mn_q;
                    max_d       = mx_q;
                    timeout_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = StReport;
                end else if (sample_valid_i) begin
                    if (cnt_q == CntMax) begin
                        period_d    = CntMax;
                        min_d       = mn_q;
                        max_d       = mx_q;
                        timeout_d   = 1'b1;
                        res_valid_d = 1'b1;
                        state_d     = StReport;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (sample_i < mn_q) begin
                            mn_d = sample_i;
                        end
                        if (sample_i > mx_q) begin
                            mx_d = sample_i;
                        end
                    end
                end
            end

            StReport: begin
                // Result stays pending regardless of en_i until the consumer takes it.
                if (res_valid_q && res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = en_i ? StSeek : StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            arm_q       <= 1'b0;
            cnt_q       <= '0;
            mn_q        <= '0;
            mx_q        <= '0;
            res_valid_q <= 1'b0;
            period_q    <= '0;
            min_q       <= '0;
            max_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            cnt_q       <= cnt_d;
            mn_q        <= mn_d;
            mx_q        <= mx_d;
            res_valid_q <= res_valid_d;
            period_q    <= period_d;
            min_q       <= min_d;
            max_q       <= max_d;
            timeout_q   <= timeout_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign period_o    = period_q;
    assign min_o       = min_q;
    assign max_o       = max_q;
    assign timeout_o   = timeout_q;

endmodule
